// File: rtl/thee_clk2phase_if.sv
// thee_clk2phase_if: two-phase clock pins, error clear and checker measurement results
interface thee_clk2phase_if #(
    parameter int CW = 8
);
    logic clkp0, clkp1, clr;
    logic locked, err_overlap, err_gap, err_order, meas_vld;
    logic [CW-1:0] hi0, hi1, gap01, gap10;
    modport master (
        output clkp0, clkp1, clr,
        input  locked, err_overlap, err_gap, err_order, meas_vld, hi0, hi1, gap01, gap10
    );
    modport slave (
        input  clkp0, clkp1, clr,
        output locked, err_overlap, err_gap, err_order, meas_vld, hi0, hi1, gap01, gap10
    );
endinterface

// File: rtl/thee_clk2phase_chk.sv
// thee_clk2phase_chk: oversampling monitor for a two-phase non-overlapping clock pair
module thee_clk2phase_chk #(
    parameter int CW       = 8,
    parameter int MIN_GAP  = 2,
    parameter int LOCK_CNT = 4,
    parameter int SYNC     = 2
) (
    input logic clk,
    input logic rst,
    thee_clk2phase_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] GAP_MIN = CW'(MIN_GAP);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
    typedef enum logic [2:0] {IDLE, H0, G01, H1, G10} state_t;
    state_t state, nxt;
    logic [SYNC-1:0] sy0, sy1;
    logic s0, s1, d0, d1, rise0, rise1, fall0, fall1;
    logic ovl, gap_ev, ord_ev, err_ev, mv, perr;
    logic [CW-1:0] cnt;
    logic [GW-1:0] good, good_nx;

    assign s0 = sy0[SYNC-1];
    assign s1 = sy1[SYNC-1];
    assign rise0 = s0 & ~d0 & ~s1;
    assign fall0 = ~s0 & d0 & ~s1;
    assign rise1 = s1 & ~d1 & ~s0;
    assign fall1 = ~s1 & d1 & ~s0;
    assign ovl = s0 & s1;
    assign err_ev = ovl | gap_ev | ord_ev;
    // a period only counts towards lock if no error was raised anywhere inside it
    assign good_nx = err_ev ? '0 : !mv ? good : perr ? '0 : good == GOOD_MAX ? good : good + 1'b1;

    always_comb begin
        nxt = IDLE;
        gap_ev = 1'b0;
        ord_ev = 1'b0;
        mv = 1'b0;
        if (!ovl) begin
            case (state)
                IDLE: nxt = rise0 ? H0 : IDLE;
                H0: nxt = fall0 ? G01 : H0;
                G01: begin
                    nxt = rise1 ? H1 : rise0 ? H0 : G01;
                    gap_ev = rise1 && cnt < GAP_MIN;
                    ord_ev = rise0;
                end
                H1: nxt = fall1 ? G10 : H1;
                G10: begin
                    nxt = rise0 ? H0 : rise1 ? H1 : G10;
                    gap_ev = rise0 && cnt < GAP_MIN;
                    ord_ev = rise1;
                    mv = rise0;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sy0 <= '0;
            sy1 <= '0;
            d0 <= 1'b0;
            d1 <= 1'b0;
            cnt <= '0;
            good <= '0;
            perr <= 1'b0;
            bus.locked <= 1'b0;
            bus.err_overlap <= 1'b0;
            bus.err_gap <= 1'b0;
            bus.err_order <= 1'b0;
            bus.meas_vld <= 1'b0;
            bus.hi0 <= '0;
            bus.hi1 <= '0;
            bus.gap01 <= '0;
            bus.gap10 <= '0;
        end else begin
            sy0 <= {sy0[SYNC-2:0], bus.clkp0};
            sy1 <= {sy1[SYNC-2:0], bus.clkp1};
            d0 <= s0;
            d1 <= s1;
            state <= nxt;
            cnt <= nxt != state ? CW'(1) : cnt == '1 ? cnt : cnt + 1'b1;
            good <= good_nx;
            bus.locked <= good_nx == GOOD_MAX;
            perr <= (nxt == H0 && state != H0) ? 1'b0 : perr | err_ev;
            bus.err_overlap <= ovl | (bus.err_overlap & ~bus.clr);
            bus.err_gap <= gap_ev | (bus.err_gap & ~bus.clr);
            bus.err_order <= ord_ev | (bus.err_order & ~bus.clr);
            bus.meas_vld <= mv;
            if (state == H0 && nxt == G01) bus.hi0 <= cnt;
            if (state == G01 && nxt == H1) bus.gap01 <= cnt;
            if (state == H1 && nxt == G10) bus.hi1 <= cnt;
            if (mv) bus.gap10 <= cnt;
        end
    end
endmodule

// File: tb/tb_thee_clk2phase_chk.sv
// tb_thee_clk2phase_chk: drives phase patterns and compares completed periods with a period-level model
module tb_thee_clk2phase_chk;
    localparam int MIN_GAP = 2;
    localparam int LOCK_CNT = 4;
    localparam int CMAX = 255;
    typedef struct packed {
        logic [7:0] hi0, gap01, hi1, gap10;
        logic locked;
    } rec_t;
    typedef struct {
        int h0, g01, h1, g10;
    } per_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    rec_t got_q[$], exp_q[$];
    per_t plan[$];
    logic exp_gap_err;
    logic prev_gap = 1'b0;
    logic gap_rise_locked = 1'b1;

    thee_clk2phase_if #(.CW(8)) bus();
    thee_clk2phase_chk #(.CW(8), .MIN_GAP(MIN_GAP), .LOCK_CNT(LOCK_CNT), .SYNC(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.meas_vld) got_q.push_back({bus.hi0, bus.gap01, bus.hi1, bus.gap10, bus.locked});
        if (bus.err_gap && !prev_gap) gap_rise_locked = bus.locked;
        prev_gap = bus.err_gap;
    end

    function automatic logic [36:0] outs();
        return {bus.locked, bus.err_overlap, bus.err_gap, bus.err_order, bus.meas_vld,
                bus.hi0, bus.hi1, bus.gap01, bus.gap10};
    endfunction

    function automatic int sat(int w);
        return w > CMAX ? CMAX : w;
    endfunction

    task automatic seg(input logic p0, input logic p1, input int n);
        bus.clkp0 = p0;
        bus.clkp1 = p1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
    endtask

    task automatic do_reset();
        bus.clkp0 = 1'b0;
        bus.clkp1 = 1'b0;
        bus.clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        plan.delete();
    endtask

    task automatic add(input int h0, input int g01, input int h1, input int g10);
        per_t p;
        p = '{h0, g01, h1, g10};
        plan.push_back(p);
    endtask

    // closing p0 pulse completes the final period's G10 so it is reported
    task automatic drive_plan();
        foreach (plan[i]) begin
            seg(1'b1, 1'b0, plan[i].h0);
            seg(1'b0, 1'b0, plan[i].g01);
            seg(1'b0, 1'b1, plan[i].h1);
            seg(1'b0, 1'b0, plan[i].g10);
        end
        seg(1'b1, 1'b0, 2);
        seg(1'b0, 1'b0, 6);
    endtask

    task automatic model_plan();
        int good = 0;
        rec_t r;
        exp_q.delete();
        exp_gap_err = 1'b0;
        foreach (plan[i]) begin
            bit bad = plan[i].g01 < MIN_GAP || plan[i].g10 < MIN_GAP;
            if (bad) exp_gap_err = 1'b1;
            good = bad ? 0 : (good < LOCK_CNT ? good + 1 : good);
            r.hi0 = 8'(sat(plan[i].h0));
            r.gap01 = 8'(sat(plan[i].g01));
            r.hi1 = 8'(sat(plan[i].h1));
            r.gap10 = 8'(sat(plan[i].g10));
            r.locked = good == LOCK_CNT;
            exp_q.push_back(r);
        end
    endtask

    task automatic test_reset();
        bus.clkp0 = 1'b1;
        bus.clkp1 = 1'b1;
        bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 37'd0) $display("FAIL reset_hold: got %h expected 0", outs());
        else passed++;
        rst = 1'b0;
        seg(1'b0, 1'b0, 8);
        checks++;
        if (outs() !== 37'd0) $display("FAIL reset_release: got %h expected 0", outs());
        else passed++;
    endtask

    task automatic test_clean();
        do_reset();
        repeat (5) add(10, 3, 10, 3);
        model_plan();
        drive_plan();
        checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL clean_count: got %0d expected %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
            else $display("FAIL clean_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
        checks++;
        if ({bus.err_overlap, bus.err_gap, bus.err_order, bus.locked} !== 4'b0001)
            $display("FAIL clean_flags: got %b expected 0001", {bus.err_overlap, bus.err_gap, bus.err_order, bus.locked});
        else passed++;
    endtask

    task automatic test_narrow_gap();
        do_reset();
        gap_rise_locked = 1'b1;
        repeat (4) add(10, 3, 10, 3);
        add(10, 1, 10, 3);
        repeat (4) add(10, 3, 10, 3);
        model_plan();
        drive_plan();
        checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL gap_count: got %0d expected %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
            else $display("FAIL gap_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
        checks++;
        if (bus.err_gap !== exp_gap_err) $display("FAIL gap_sticky: got %b expected %b", bus.err_gap, exp_gap_err);
        else passed++;
        checks++;
        if (gap_rise_locked !== 1'b0) $display("FAIL gap_lock_drop: got %b expected 0", gap_rise_locked);
        else passed++;
        pulse_clr();
        checks++;
        if ({bus.err_gap, bus.locked, bus.hi0} !== {1'b0, 1'b1, 8'd2})
            $display("FAIL gap_clr: got %h expected %h", {bus.err_gap, bus.locked, bus.hi0}, {1'b0, 1'b1, 8'd2});
        else passed++;
    endtask

    task automatic test_overlap();
        rec_t e0, e1;
        e0 = '{8'd10, 8'd3, 8'd10, 8'd3, 1'b0};
        e1 = '{8'd8, 8'd3, 8'd8, 8'd3, 1'b0};
        do_reset();
        seg(1'b1, 1'b0, 10);
        seg(1'b0, 1'b0, 3);
        seg(1'b0, 1'b1, 10);
        seg(1'b0, 1'b0, 3);
        seg(1'b1, 1'b0, 10);
        seg(1'b1, 1'b1, 4);
        seg(1'b0, 1'b0, 6);
        checks++;
        if ({bus.err_overlap, 32'(got_q.size())} !== {1'b1, 32'd1})
            $display("FAIL ovl_flag: got ovl=%b meas=%0d expected ovl=1 meas=1", bus.err_overlap, got_q.size());
        else passed++;
        seg(1'b1, 1'b0, 8);
        seg(1'b0, 1'b0, 3);
        seg(1'b0, 1'b1, 8);
        seg(1'b0, 1'b0, 3);
        seg(1'b1, 1'b0, 2);
        seg(1'b0, 1'b0, 6);
        checks++;
        if (got_q.size() !== 2 || got_q[0] !== e0 || got_q[1] !== e1)
            $display("FAIL ovl_restart: got n=%0d %h %h expected %h %h", got_q.size(), got_q[0], got_q[1], e0, e1);
        else passed++;
        pulse_clr();
        checks++;
        if (bus.err_overlap !== 1'b0) $display("FAIL ovl_clr: got %b expected 0", bus.err_overlap);
        else passed++;
        seg(1'b1, 1'b1, 4);
        seg(1'b0, 1'b0, 6);
        checks++;
        if ({bus.err_overlap, bus.err_gap, bus.err_order, 32'(got_q.size())} !== {3'b100, 32'd2})
            $display("FAIL ovl_simul_rise: got ovl/gap/ord=%b%b%b meas=%0d expected 100 meas=2",
                     bus.err_overlap, bus.err_gap, bus.err_order, got_q.size());
        else passed++;
    endtask

    task automatic test_order();
        rec_t e0, e1;
        e0 = '{8'd9, 8'd3, 8'd5, 8'd4, 1'b0};
        e1 = '{8'd2, 8'd7, 8'd4, 8'd3, 1'b0};
        do_reset();
        seg(1'b1, 1'b0, 6);
        seg(1'b0, 1'b0, 4);
        seg(1'b1, 1'b0, 9);
        seg(1'b0, 1'b0, 3);
        seg(1'b0, 1'b1, 5);
        seg(1'b0, 1'b0, 4);
        seg(1'b1, 1'b0, 2);
        seg(1'b0, 1'b0, 6);
        checks++;
        if ({bus.err_order, bus.err_gap} !== 2'b10 || got_q.size() !== 1 || got_q[0] !== e0)
            $display("FAIL order_p0: got ord/gap=%b%b n=%0d rec=%h expected 10 n=1 rec=%h",
                     bus.err_order, bus.err_gap, got_q.size(), got_q[0], e0);
        else passed++;
        pulse_clr();
        checks++;
        if (bus.err_order !== 1'b0) $display("FAIL order_clr: got %b expected 0", bus.err_order);
        else passed++;
        seg(1'b0, 1'b1, 5);
        seg(1'b0, 1'b0, 3);
        seg(1'b0, 1'b1, 4);
        seg(1'b0, 1'b0, 3);
        seg(1'b1, 1'b0, 2);
        seg(1'b0, 1'b0, 6);
        checks++;
        if (bus.err_order !== 1'b1 || got_q.size() !== 2 || got_q[1] !== e1)
            $display("FAIL order_p1: got ord=%b n=%0d rec=%h expected ord=1 n=2 rec=%h",
                     bus.err_order, got_q.size(), got_q[1], e1);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        seg(1'b1, 1'b0, 300);
        seg(1'b0, 1'b0, 6);
        checks++;
        if (bus.hi0 !== 8'd255) $display("FAIL sat_hi0: got %0d expected 255", bus.hi0);
        else passed++;
        seg(1'b0, 1'b1, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (outs() !== 37'd0) $display("FAIL sat_midreset: got %h expected 0", outs());
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seg(1'b0, 1'b1, 4);
        seg(1'b0, 1'b0, 4);
        seg(1'b0, 1'b1, 5);
        seg(1'b0, 1'b0, 6);
        checks++;
        if (outs() !== 37'd0 || got_q.size() !== 0)
            $display("FAIL sat_idle_wait: got %h n=%0d expected 0 n=0", outs(), got_q.size());
        else passed++;
    endtask

    // clr is held so it is sampled on exactly the edge that registers the narrow gap
    task automatic test_clr_collision();
        do_reset();
        seg(1'b1, 1'b0, 8);
        seg(1'b0, 1'b0, 1);
        bus.clkp1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.err_gap !== 1'b0) $display("FAIL clr_pre_event: got %b expected 0", bus.err_gap);
        else passed++;
        pulse_clr();
        checks++;
        if (bus.err_gap !== 1'b1) $display("FAIL clr_collision: got %b expected 1", bus.err_gap);
        else passed++;
        seg(1'b0, 1'b1, 5);
        seg(1'b0, 1'b0, 3);
        checks++;
        if ({bus.err_gap, bus.gap01} !== {1'b1, 8'd1}) $display("FAIL clr_sticky: got %h expected 101", {bus.err_gap, bus.gap01});
        else passed++;
        pulse_clr();
        checks++;
        if (bus.err_gap !== 1'b0) $display("FAIL clr_after: got %b expected 0", bus.err_gap);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        repeat (16) begin
            int h0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 280)) : int'($urandom_range(1, 20));
            add(h0, int'($urandom_range(1, 6)), int'($urandom_range(1, 20)), int'($urandom_range(1, 6)));
        end
        model_plan();
        drive_plan();
        checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
            else $display("FAIL rand_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
        checks++;
        if ({bus.err_gap, bus.err_overlap, bus.err_order, bus.locked} !== {exp_gap_err, 2'b00, exp_q[$].locked})
            $display("FAIL rand_flags: got %b expected %b", {bus.err_gap, bus.err_overlap, bus.err_order, bus.locked},
                     {exp_gap_err, 2'b00, exp_q[$].locked});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_narrow_gap();
        test_overlap();
        test_order();
        test_saturation();
        test_clr_collision();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
